lift_car_driver: RTL
====================

LIFT_CAR_DRIVER -- requirements
Module: lift_car_driver

Interface
REQ-001 Parameter FLOOR_TICKS, default 4: clock cycles to travel one floor; legal range 1..255.
REQ-002 Parameter DOOR_TICKS, default 3: clock cycles the door stays open; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port NextFloor, input, 3: target floor from the lift controller; legal values 0..4.
REQ-006 Port NextStopDirection, input, 2: direction from the lift controller; 10 = up, 01 = down, 00 = stay, 11 = invalid.
REQ-007 Port DoorBlock, input, 1: door obstruction sensor, active high.
REQ-008 Port CurrentFloor, output, 3: floor the car is at or last passed.
REQ-009 Port MotorUp, output, 1: drive car upward.
REQ-010 Port MotorDown, output, 1: drive car downward.
REQ-011 Port DoorOpen, output, 1: door open command.
REQ-012 Port Arrived, output, 1: one-cycle pulse on arrival at the target floor.
REQ-013 Port Busy, output, 1: high whenever the FSM is not in IDLE.
REQ-014 Port Fault, output, 1: sticky invalid-command flag.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, MOVE, DOOR and FAULT.
REQ-016 All outputs SHALL be registered, and each SHALL change only on a clk edge or on reset assertion.
REQ-017 In IDLE, if NextStopDirection = 11 or NextFloor > 4, the next state SHALL be FAULT.
REQ-018 In IDLE, a move request is accepted when NextStopDirection = 10 with NextFloor > CurrentFloor, or NextStopDirection = 01 with NextFloor < CurrentFloor.
REQ-019 On accepting a move request, the block SHALL latch the target, enter MOVE and clear the tick counter; on the same edge it SHALL assert MotorUp (for 10) or MotorDown (for 01).
REQ-020 Any other IDLE input combination (00, NextFloor = CurrentFloor, or a direction inconsistent with the target) SHALL leave the state in IDLE with all outputs 0 except CurrentFloor.
REQ-021 In MOVE, the tick counter SHALL increment each cycle; when it equals FLOOR_TICKS-1 it SHALL wrap to 0 and CurrentFloor SHALL step by +1 (up) or -1 (down).
REQ-022 The edge on which CurrentFloor becomes the latched target SHALL do all of the following: enter DOOR, clear both Motor outputs, set DoorOpen = 1, and pulse Arrived = 1 for exactly that cycle.
REQ-023 While in MOVE, changes on NextFloor and NextStopDirection SHALL be ignored; there is no re-targeting and no fault check.
REQ-024 MotorUp and MotorDown SHALL never be 1 simultaneously.
REQ-025 CurrentFloor SHALL never leave the range 0..4.
REQ-026 In DOOR, the door counter SHALL start at 0 and increment each cycle; if DoorBlock = 1 the counter SHALL reload to 0 instead.
REQ-027 DOOR SHALL exit to IDLE on the edge where the door counter = DOOR_TICKS-1 and DoorBlock = 0; that edge SHALL clear DoorOpen.
REQ-028 With DoorBlock held low, DoorOpen SHALL be high for exactly DOOR_TICKS cycles.
REQ-029 In FAULT, the block SHALL hold Fault = 1, both Motors = 0, DoorOpen = 0, Busy = 1 and CurrentFloor unchanged, ignore all inputs, and leave FAULT only on reset.
REQ-030 Busy SHALL be registered as (next state != IDLE).

Reset
REQ-031 While reset = 0, the block SHALL immediately force IDLE, CurrentFloor = 0, all counters = 0 and every other output = 0, regardless of clk.
REQ-032 A reset asserted mid-MOVE or mid-DOOR SHALL abandon the operation; no Arrived pulse shall be produced.
REQ-033 The first clk edge with reset = 1 SHALL evaluate IDLE rules (REQ-017 to REQ-020) against the current inputs.

Verification (FLOOR_TICKS = 4, DOOR_TICKS = 3)
REQ-034 Scenario: CurrentFloor = 0, NextFloor = 2, dir = 10. Required: MotorUp high for 8 cycles; CurrentFloor becomes 1 after 4 cycles and 2 after 8; Arrived pulses once with CurrentFloor = 2; DoorOpen high 3 cycles; then Busy = 0.
REQ-035 Scenario: from floor 2, NextFloor = 0, dir = 01. Required: MotorDown high for 8 cycles; CurrentFloor steps 2 -> 1 -> 0; single Arrived pulse; MotorUp stays 0 throughout.
REQ-036 Scenario: in DOOR, DoorBlock held high for 5 cycles then released. Required: DoorOpen stays 1 throughout and falls exactly 3 cycles after DoorBlock falls.
REQ-037 Scenario: in IDLE, dir = 11; separately, NextFloor = 5 with dir = 10. Required in each case: Fault = 1 on the next edge, Motors = 0, held through further input changes until reset.
REQ-038 Scenario: NextFloor changed 3 -> 1 mid-MOVE; separately, dir = 10 with NextFloor < CurrentFloor in IDLE. Required: the car still stops at 3; the IDLE case stays IDLE with Fault = 0.
REQ-039 Scenario: reset driven low between clk edges mid-MOVE at floor 1. Required: CurrentFloor = 0, Motors = 0, Busy = 0 immediately, and no Arrived pulse.

Source files
------------

// File: rtl/lift_car_driver.sv
// -----------------------------------------------------------------------------
// lift_car_driver
//
// Drives a single lift car between floors 0..4. The lift controller presents a
// target floor and a direction; the car travels one floor every FLOOR_TICKS
// cycles, opens its door for DOOR_TICKS cycles on arrival (held open while the
// door is obstructed), and then returns to IDLE. An illegal command seen in
// IDLE locks the block into FAULT until reset.
//
// Parameters
//   FLOOR_TICKS : cycles to travel one floor (1..255)
//   DOOR_TICKS  : cycles the door stays open with no obstruction (1..255)
//
// Ports
//   clk               : clock, all state changes on the rising edge
//   reset             : asynchronous active-low reset
//   NextFloor[2:0]    : target floor from the controller (legal 0..4)
//   NextStopDirection : 2'b10 up, 2'b01 down, 2'b00 stay, 2'b11 invalid
//   DoorBlock         : door obstruction sensor, active high
//   CurrentFloor[2:0] : floor the car is at or last passed
//   MotorUp/MotorDown : motor drive commands (never both high)
//   DoorOpen          : door open command
//   Arrived           : one-cycle pulse on the edge the car reaches its target
//   Busy              : high whenever the FSM is (about to be) outside IDLE
//   Fault             : sticky invalid-command flag
//   o_dbg_state[1:0]  : current FSM state, for observation only
//
// Command sampling: there is no valid/ready handshake. NextFloor and
// NextStopDirection are treated as a level command that is sampled on every
// clock edge while the FSM is in IDLE and accepted on the edge that takes the
// FSM to MOVE; in every other state the command inputs are ignored, so the
// controller sees acceptance as Busy rising and completion as Arrived.
// -----------------------------------------------------------------------------
module lift_car_driver #(
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] NextFloor,
  input  logic [1:0] NextStopDirection,
  input  logic       DoorBlock,
  output logic [2:0] CurrentFloor,
  output logic       MotorUp,
  output logic       MotorDown,
  output logic       DoorOpen,
  output logic       Arrived,
  output logic       Busy,
  output logic       Fault,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DOOR  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0] FLOOR_LAST = 8'(FLOOR_TICKS - 1);
  localparam logic [7:0] DOOR_LAST  = 8'(DOOR_TICKS - 1);
  localparam logic [2:0] TOP_FLOOR  = 3'd4;
  localparam logic [1:0] DIR_UP     = 2'b10;
  localparam logic [1:0] DIR_DOWN   = 2'b01;
  localparam logic [1:0] DIR_BAD    = 2'b11;

  state_t     r_state;
  logic [2:0] r_target;
  logic       r_dir_up;
  logic [7:0] r_tick;
  logic [7:0] r_door_cnt;

  logic       w_cmd_invalid;
  logic       w_req_up;
  logic       w_req_down;
  logic       w_floor_wrap;
  logic [2:0] w_floor_next;
  logic       w_door_last;

  // Command decode, only acted on in IDLE. The invalid check has priority,
  // so an out-of-range target with a legal direction still faults.
  always_comb begin
    w_cmd_invalid = (NextStopDirection == DIR_BAD) || (NextFloor > TOP_FLOOR);
    w_req_up      = (NextStopDirection == DIR_UP)   && (NextFloor > CurrentFloor);
    w_req_down    = (NextStopDirection == DIR_DOWN) && (NextFloor < CurrentFloor);
  end

  // Travel and door timing. The floor only ever steps toward a target that
  // was range-checked on acceptance, so CurrentFloor stays within 0..4.
  always_comb begin
    w_floor_wrap = (r_tick == FLOOR_LAST);
    w_floor_next = r_dir_up ? (CurrentFloor + 3'd1) : (CurrentFloor - 3'd1);
    w_door_last  = (r_door_cnt == DOOR_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_target     <= 3'd0;
      r_dir_up     <= 1'b0;
      r_tick       <= 8'd0;
      r_door_cnt   <= 8'd0;
      CurrentFloor <= 3'd0;
      MotorUp      <= 1'b0;
      MotorDown    <= 1'b0;
      DoorOpen     <= 1'b0;
      Arrived      <= 1'b0;
      Busy         <= 1'b0;
      Fault        <= 1'b0;
    end else begin
      // Arrived is a single-cycle pulse; only the arrival edge sets it.
      Arrived <= 1'b0;

      case (r_state)
        IDLE: begin
          MotorUp   <= 1'b0;
          MotorDown <= 1'b0;
          DoorOpen  <= 1'b0;
          Busy      <= 1'b0;
          Fault     <= 1'b0;
          r_tick    <= 8'd0;
          if (w_cmd_invalid) begin
            r_state <= FAULT;
            Fault   <= 1'b1;
            Busy    <= 1'b1;
          end else if (w_req_up) begin
            r_state  <= MOVE;
            r_target <= NextFloor;
            r_dir_up <= 1'b1;
            MotorUp  <= 1'b1;
            Busy     <= 1'b1;
          end else if (w_req_down) begin
            r_state   <= MOVE;
            r_target  <= NextFloor;
            r_dir_up  <= 1'b0;
            MotorDown <= 1'b1;
            Busy      <= 1'b1;
          end
        end

        MOVE: begin
          // Command inputs are deliberately not looked at here: no
          // re-targeting and no fault check while travelling.
          if (w_floor_wrap) begin
            r_tick       <= 8'd0;
            CurrentFloor <= w_floor_next;
            if (w_floor_next == r_target) begin
              r_state    <= DOOR;
              r_door_cnt <= 8'd0;
              MotorUp    <= 1'b0;
              MotorDown  <= 1'b0;
              DoorOpen   <= 1'b1;
              Arrived    <= 1'b1;
            end
          end else begin
            r_tick <= r_tick + 8'd1;
          end
        end

        DOOR: begin
          // An obstruction restarts the full open period from zero.
          if (DoorBlock) begin
            r_door_cnt <= 8'd0;
          end else if (w_door_last) begin
            r_state    <= IDLE;
            r_door_cnt <= 8'd0;
            DoorOpen   <= 1'b0;
            Busy       <= 1'b0;
          end else begin
            r_door_cnt <= r_door_cnt + 8'd1;
          end
        end

        FAULT: begin
          // Terminal until reset; everything held safe.
          MotorUp   <= 1'b0;
          MotorDown <= 1'b0;
          DoorOpen  <= 1'b0;
          Busy      <= 1'b1;
          Fault     <= 1'b1;
        end

        default: begin
          r_state <= FAULT;
          Busy    <= 1'b1;
          Fault   <= 1'b1;
        end
      endcase
    end
  end

  assign o_dbg_state = r_state;

  // Safety invariants of the car.
  a_motor_excl: assert property (@(posedge clk) disable iff (!reset)
    !(MotorUp && MotorDown));
  a_floor_range: assert property (@(posedge clk) disable iff (!reset)
    CurrentFloor <= TOP_FLOOR);

endmodule
